als_error_monitor: RTL and testbench

ALS_ERROR_MONITOR -- requirements
Module: als_error_monitor

---
 rtl/als_error_monitor.sv | 167 ++++++++++++++++
 tb/tb_als_error_monitor.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/als_error_monitor.sv
// Error monitor for an approximate adder: counts samples and erroneous samples, and
// tracks the maximum and saturating sum of |exact - approx| over a measurement run.
module als_error_monitor #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in0,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH:0]     approx_sum,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [WIDTH:0]     max_ed,
  output logic [ACC_W-1:0]   sum_ed
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_acc_cnt;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_done;

  logic             r_s1_vld;
  logic [WIDTH:0]   r_s1_exact;
  logic [WIDTH:0]   r_s1_approx;

  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [WIDTH:0]   r_max_ed;
  logic [ACC_W-1:0] r_sum_ed;

  logic             w_accept;
  logic             w_start_acc;
  logic [WIDTH:0]   w_ed;
  logic [ACC_W:0]   w_sum_wide;
  logic [ACC_W-1:0] w_sum_next;

  assign w_accept    = in_valid && r_in_ready;
  assign w_start_acc = start && (r_state != ST_RUN);

  // Run-control FSM; in_ready is precomputed so it is a plain register output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_num      <= CNT_W'(0);
      r_acc_cnt  <= CNT_W'(0);
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_acc_cnt <= CNT_W'(0);
            r_num     <= num_samples;
            if (num_samples != CNT_W'(0)) begin
              r_state    <= ST_RUN;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b1;
              r_done     <= 1'b0;
            end else begin
              r_state    <= ST_DONE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_acc_cnt  <= r_acc_cnt + CNT_W'(1);
            r_in_ready <= (r_acc_cnt + CNT_W'(1)) < r_num;
          end
          // Every accepted sample has retired once sample_cnt reaches the target.
          if (r_sample_cnt == r_num) begin
            r_state    <= ST_DONE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: exact reference sum alongside the approximate result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld    <= 1'b0;
      r_s1_exact  <= (WIDTH+1)'(0);
      r_s1_approx <= (WIDTH+1)'(0);
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_exact  <= {1'b0, in0} + {1'b0, in1};
        r_s1_approx <= approx_sum;
      end
    end
  end

  // Error distance and saturating accumulation.
  always_comb begin
    w_ed       = (WIDTH+1)'(0);
    w_sum_wide = (ACC_W+1)'(0);
    w_sum_next = r_sum_ed;
    if (r_s1_exact >= r_s1_approx) begin
      w_ed = r_s1_exact - r_s1_approx;
    end else begin
      w_ed = r_s1_approx - r_s1_exact;
    end
    w_sum_wide = {1'b0, r_sum_ed} + (ACC_W+1)'(w_ed);
    if (w_sum_wide[ACC_W]) begin
      w_sum_next = {ACC_W{1'b1}};
    end else begin
      w_sum_next = w_sum_wide[ACC_W-1:0];
    end
  end

  // Stage 2: result registers, cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      r_sample_cnt <= CNT_W'(0);
      r_err_cnt    <= CNT_W'(0);
      r_max_ed     <= (WIDTH+1)'(0);
      r_sum_ed     <= ACC_W'(0);
    end else if (r_s1_vld) begin
      r_sample_cnt <= r_sample_cnt + CNT_W'(1);
      if (w_ed != (WIDTH+1)'(0)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
      if (w_ed > r_max_ed) begin
        r_max_ed <= w_ed;
      end
      r_sum_ed <= w_sum_next;
    end
  end

  assign in_ready   = r_in_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign sample_cnt = r_sample_cnt;
  assign err_cnt    = r_err_cnt;
  assign max_ed     = r_max_ed;
  assign sum_ed     = r_sum_ed;

endmodule

// File: tb/tb_als_error_monitor.sv
// Randomized self-checking bench for als_error_monitor against a list-based reference model.
module tb_als_error_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, in_valid;
  logic [31:0] num_samples;
  logic [15:0] in0, in1;
  logic [16:0] approx_sum;

  logic        in_ready, busy, done;
  logic [31:0] sample_cnt, err_cnt;
  logic [16:0] max_ed;
  logic [47:0] sum_ed;

  logic        s_in_ready, s_busy, s_done;
  logic [31:0] s_sample_cnt, s_err_cnt;
  logic [16:0] s_max_ed;
  logic [16:0] s_sum_ed;

  als_error_monitor dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in0(in0), .in1(in1),
    .approx_sum(approx_sum), .busy(busy), .done(done), .sample_cnt(sample_cnt),
    .err_cnt(err_cnt), .max_ed(max_ed), .sum_ed(sum_ed)
  );

  als_error_monitor #(.WIDTH(16), .CNT_W(32), .ACC_W(17)) dut_s (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(s_in_ready), .in0(in0), .in1(in1),
    .approx_sum(approx_sum), .busy(s_busy), .done(s_done), .sample_cnt(s_sample_cnt),
    .err_cnt(s_err_cnt), .max_ed(s_max_ed), .sum_ed(s_sum_ed)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state: statistics over the list of accepted triples.
  longint unsigned m_cnt, m_err, m_max, m_sum, m_sum_s;
  int dir_a[$];
  int dir_b[$];
  int dir_s[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_cnt = 0; m_err = 0; m_max = 0; m_sum = 0; m_sum_s = 0;
  endtask

  task automatic model_add(input longint unsigned a, input longint unsigned b,
                           input longint unsigned s);
    longint unsigned exact, ed;
    exact = a + b;
    ed = (exact > s) ? exact - s : s - exact;
    m_cnt++;
    if (ed != 0) m_err++;
    if (ed > m_max) m_max = ed;
    m_sum = m_sum + ed;
    if (m_sum > 64'h0000_FFFF_FFFF_FFFF) m_sum = 64'h0000_FFFF_FFFF_FFFF;
    m_sum_s = m_sum_s + ed;
    if (m_sum_s > 64'd131071) m_sum_s = 64'd131071;
  endtask

  // One complete run of n samples; uses the directed queues first, then random triples.
  task automatic run_and_check(input int n, input int vprob, input string tag);
    int acc = 0;
    int budget = 0;
    int idx = 0;
    int a, b, s, mode;
    logic [31:0]  h_cnt, h_err;
    logic [16:0]  h_max;
    logic [47:0]  h_sum;
    start = 1'b1; num_samples = n; tick();
    start = 1'b0; num_samples = $urandom;
    model_clear();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL %s run_entry busy=%b done=%b exp busy=1 done=0", tag, busy, done);
    end
    while (acc < n && budget < 2000) begin
      checks++;
      if (in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
        failures++; $display("FAIL %s in_ready got=%b exp=1 acc=%0d", tag, in_ready, acc);
      end
      start = ($urandom_range(9) == 0);
      num_samples = $urandom_range(3);
      in_valid = ($urandom_range(99) < vprob);
      if (idx < dir_a.size()) begin
        a = dir_a[idx]; b = dir_b[idx]; s = dir_s[idx];
      end else begin
        a = $urandom_range(65535); b = $urandom_range(65535);
        mode = $urandom_range(2);
        if (mode == 0) s = a + b;
        else if (mode == 1) s = $urandom_range(131071);
        else s = (a + b + $urandom_range(1, 40)) % 131072;
      end
      in0 = a[15:0]; in1 = b[15:0]; approx_sum = s[16:0];
      if (in_valid) begin
        model_add(a, b, s);
        acc++; idx++;
      end
      tick();
      budget++;
    end
    start = 1'b0; in_valid = 1'b0;
    checks++;
    if (acc < n) begin
      failures++; $display("FAIL %s accept_timeout got=%0d exp=%0d", tag, acc, n);
    end
    checks++;
    if (in_ready !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL %s after_last in_ready=%b done=%b exp 0 0", tag, in_ready, done);
    end
    tick();
    checks++;
    if (done !== 1'b0 || sample_cnt !== 32'(m_cnt)) begin
      failures++; $display("FAIL %s last_retire done=%b cnt=%0d exp done=0 cnt=%0d", tag, done, sample_cnt, m_cnt);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || s_done !== 1'b1) begin
      failures++; $display("FAIL %s done_timing done=%b busy=%b exp 1 0", tag, done, busy);
    end
    checks++;
    if (sample_cnt !== 32'(m_cnt) || err_cnt !== 32'(m_err)) begin
      failures++; $display("FAIL %s counts got=%0d/%0d exp=%0d/%0d", tag, sample_cnt, err_cnt, m_cnt, m_err);
    end
    checks++;
    if (max_ed !== 17'(m_max) || sum_ed !== 48'(m_sum)) begin
      failures++; $display("FAIL %s ed_stats got max=%0d sum=%0d exp max=%0d sum=%0d", tag, max_ed, sum_ed, m_max, m_sum);
    end
    checks++;
    if (s_sum_ed !== 17'(m_sum_s) || s_err_cnt !== 32'(m_err)) begin
      failures++; $display("FAIL %s narrow_acc got sum=%0d err=%0d exp sum=%0d err=%0d", tag, s_sum_ed, s_err_cnt, m_sum_s, m_err);
    end
    h_cnt = sample_cnt; h_err = err_cnt; h_max = max_ed; h_sum = sum_ed;
    in_valid = 1'b1; in0 = 16'hFFFF; in1 = 16'hFFFF; approx_sum = 17'd0;
    repeat (3) tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || sample_cnt !== 32'(m_cnt) || err_cnt !== 32'(m_err) ||
        max_ed !== 17'(m_max) || sum_ed !== 48'(m_sum) || done !== 1'b1) begin
      failures++; $display("FAIL %s done_hold cnt=%0d err=%0d max=%0d sum=%0d was %0d %0d %0d %0d",
                           tag, sample_cnt, err_cnt, max_ed, sum_ed, h_cnt, h_err, h_max, h_sum);
    end
    dir_a.delete(); dir_b.delete(); dir_s.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sample_cnt !== 32'd0 ||
        err_cnt !== 32'd0 || max_ed !== 17'd0 || sum_ed !== 48'd0) begin
      failures++; $display("FAIL reset rdy=%b busy=%b done=%b cnt=%0d err=%0d max=%0d sum=%0d exp all 0",
                           in_ready, busy, done, sample_cnt, err_cnt, max_ed, sum_ed);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL idle_hold busy=%b done=%b rdy=%b exp 0 0 0", busy, done, in_ready);
    end
  endtask

  task automatic test_exact();
    for (int i = 0; i < 4; i++) begin
      int a = $urandom_range(65535);
      int b = $urandom_range(65535);
      dir_a.push_back(a); dir_b.push_back(b); dir_s.push_back(a + b);
    end
    run_and_check(4, 100, "exact");
    checks++;
    if (sample_cnt !== 32'd4 || err_cnt !== 32'd0 || max_ed !== 17'd0 || sum_ed !== 48'd0) begin
      failures++; $display("FAIL exact_const got %0d %0d %0d %0d exp 4 0 0 0", sample_cnt, err_cnt, max_ed, sum_ed);
    end
  endtask

  task automatic test_directed();
    dir_a = '{65535, 100}; dir_b = '{1, 200}; dir_s = '{0, 296};
    run_and_check(2, 100, "directed");
    checks++;
    if (sample_cnt !== 32'd2 || err_cnt !== 32'd2 || max_ed !== 17'd65536 || sum_ed !== 48'd65540) begin
      failures++; $display("FAIL directed_const got %0d %0d %0d %0d exp 2 2 65536 65540", sample_cnt, err_cnt, max_ed, sum_ed);
    end
  endtask

  task automatic test_zero();
    start = 1'b1; num_samples = 32'd0; tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || sample_cnt !== 32'd0 ||
        err_cnt !== 32'd0 || max_ed !== 17'd0 || sum_ed !== 48'd0) begin
      failures++; $display("FAIL zero_run done=%b busy=%b rdy=%b cnt=%0d err=%0d max=%0d sum=%0d exp 1 0 0 0 0 0 0",
                           done, busy, in_ready, sample_cnt, err_cnt, max_ed, sum_ed);
    end
    in_valid = 1'b1; in0 = 16'd5; in1 = 16'd5; approx_sum = 17'd0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (in_ready !== 1'b0 || sample_cnt !== 32'd0) begin
        failures++; $display("FAIL zero_ready cycle=%0d rdy=%b cnt=%0d exp 0 0", c, in_ready, sample_cnt);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    start = 1'b1; num_samples = 32'd3; tick();
    start = 1'b0;
    in_valid = 1'b1; in0 = 16'd10; in1 = 16'd20; approx_sum = 17'd29;
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if (in_ready !== (c <= 3)) begin
        failures++; $display("FAIL overrun_ready cycle=%0d got=%b exp=%b", c, in_ready, (c <= 3));
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (sample_cnt !== 32'd3 || err_cnt !== 32'd3 || sum_ed !== 48'd3 || done !== 1'b1) begin
      failures++; $display("FAIL overrun_result cnt=%0d err=%0d sum=%0d done=%b exp 3 3 3 1", sample_cnt, err_cnt, sum_ed, done);
    end
  endtask

  task automatic test_mid_reset();
    start = 1'b1; num_samples = 32'd5; tick();
    start = 1'b0;
    in_valid = 1'b1; in0 = 16'd1000; in1 = 16'd1000; approx_sum = 17'd0;
    tick(); tick();
    rst = 1'b1; tick();
    rst = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || sample_cnt !== 32'd0 ||
          err_cnt !== 32'd0 || max_ed !== 17'd0 || sum_ed !== 48'd0) begin
        failures++; $display("FAIL mid_reset cycle=%0d busy=%b done=%b rdy=%b cnt=%0d err=%0d max=%0d sum=%0d exp all 0",
                             c, busy, done, in_ready, sample_cnt, err_cnt, max_ed, sum_ed);
      end
      tick();
    end
    run_and_check(3, 70, "post_reset");
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) begin
      dir_a.push_back(65535); dir_b.push_back(1); dir_s.push_back(0);
    end
    run_and_check(5, 100, "saturate");
    checks++;
    if (s_sum_ed !== 17'd131071 || s_err_cnt !== 32'd5 || sum_ed !== 48'd327680) begin
      failures++; $display("FAIL sat_const got narrow=%0d err=%0d wide=%0d exp 131071 5 327680", s_sum_ed, s_err_cnt, sum_ed);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      run_and_check($urandom_range(1, 40), $urandom_range(30, 100), $sformatf("rand%0d", r));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; num_samples = 32'd0;
    in0 = 16'd0; in1 = 16'd0; approx_sum = 17'd0;
    test_reset();
    test_exact();
    test_directed();
    test_zero();
    test_back_to_back();
    test_mid_reset();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
